// File: rtl/regfile_scan_disp.sv
// Register file: one write port, two combinational read ports with write-through bypass.
// A scanner shows one register in hex on a multiplexed 7-segment display.
module regfile_scan_disp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned DISP_REG   = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regwrite,
  input  logic [ADDR_W-1:0]     writeaddr,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  regread1,
  input  logic                  regread2,
  input  logic [ADDR_W-1:0]     readaddr1,
  input  logic [ADDR_W-1:0]     readaddr2,
  output logic [DATA_W-1:0]     readdata1,
  output logic [DATA_W-1:0]     readdata2,
  output logic [6:0]            leds,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ADDR_W-1:0] DISP_ADDR = ADDR_W'(DISP_REG);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [DATA_W-1:0]     snap_q, snap_d;
  logic                  load_pend_q, load_pend_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            leds_q, leds_d;
  logic                  div_wrap_c;
  logic [3:0]            nib_c;

  // Array update; r0 is never written so it stays zero.
  always_comb begin
    mem_d = mem_q;
    if (regwrite && writeaddr != '0) begin
      mem_d[writeaddr] = writedata;
    end
  end

  // Read ports: zero checks come before bypass so a write to r0 never forwards.
  always_comb begin
    readdata1 = '0;
    if (!rst && regread1 && readaddr1 != '0) begin
      if (regwrite && writeaddr == readaddr1) readdata1 = writedata;
      else                                    readdata1 = mem_q[readaddr1];
    end
  end

  always_comb begin
    readdata2 = '0;
    if (!rst && regread2 && readaddr2 != '0) begin
      if (regwrite && writeaddr == readaddr2) readdata2 = writedata;
      else                                    readdata2 = mem_q[readaddr2];
    end
  end

  // Scanner: snapshot is refreshed only between scans so a scan never tears.
  always_comb begin
    div_wrap_c  = (div_cnt_q == CNT_LAST);
    div_cnt_d   = div_wrap_c ? '0 : div_cnt_q + CNT_W'(1);
    dig_d       = dig_q;
    snap_d      = snap_q;
    load_pend_d = 1'b0;
    nib_c       = 4'(snap_q >> {dig_q, 2'b00});
    an_d        = NUM_DIGITS'(1) << dig_q;
    leds_d      = hex7(nib_c);
    if (div_wrap_c) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
    end
    if (load_pend_q || (div_wrap_c && dig_q == DIG_LAST)) begin
      snap_d = mem_q[DISP_ADDR];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      div_cnt_q   <= '0;
      dig_q       <= '0;
      snap_q      <= '0;
      load_pend_q <= 1'b1;
      an_q        <= '0;
      leds_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      div_cnt_q   <= div_cnt_d;
      dig_q       <= dig_d;
      snap_q      <= snap_d;
      load_pend_q <= load_pend_d;
      an_q        <= an_d;
      leds_q      <= leds_d;
    end
  end

  assign an   = an_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_regfile_scan_disp.sv
// Directed bench for regfile_scan_disp with a 4-cycle digit period.
module tb_regfile_scan_disp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ND     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              regwrite;
  logic [ADDR_W-1:0] writeaddr;
  logic [DATA_W-1:0] writedata;
  logic              regread1, regread2;
  logic [ADDR_W-1:0] readaddr1, readaddr2;
  logic [DATA_W-1:0] readdata1, readdata2;
  logic [6:0]        leds;
  logic [ND-1:0]     an;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scan_disp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DIGITS(ND), .SCAN_DIV(4), .DISP_REG(23)
  ) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .writeaddr(writeaddr), .writedata(writedata),
    .regread1(regread1), .regread2(regread2), .readaddr1(readaddr1), .readaddr2(readaddr2),
    .readdata1(readdata1), .readdata2(readdata2), .leds(leds), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until 'an' equals the given one-hot value.
  task automatic wait_an(input logic [ND-1:0] val, input string tag);
    int n;
    n = 0;
    while (an !== val && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(an), 32'(val));
  endtask

  // Check a full scan of four 4-cycle digit periods, starting on the first 0001 cycle.
  task automatic chk_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] segs [4];
    logic [ND-1:0] exp_an;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int c = 0; c < 16; c++) begin
      exp_an = ND'(1) << (c / 4);
      chk($sformatf("%s_an_%0d", tag, c), 32'(an), 32'(exp_an));
      chk($sformatf("%s_leds_%0d", tag, c), 32'(leds), 32'(segs[c / 4]));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; regwrite = 1'b0; writeaddr = '0; writedata = '0;
    regread1 = 1'b1; regread2 = 1'b1; readaddr1 = 5'd3; readaddr2 = 5'd4;
    tick();
    tick();
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_rd1", readdata1, 32'h0);

    // First post-reset edge shows digit 0 of an all-zero snapshot.
    rst = 1'b0;
    tick();
    chk("post_rst_an", 32'(an), 32'h1);
    chk("post_rst_leds", 32'(leds), 32'h3F);

    for (int i = 1; i < 32; i++) begin
      readaddr1 = ADDR_W'(i);
      readaddr2 = ADDR_W'(i);
      #1;
      chk($sformatf("clr_rd1_r%0d", i), readdata1, 32'h0);
      chk($sformatf("clr_rd2_r%0d", i), readdata2, 32'h0);
    end

    // Plain write then read on both ports.
    regwrite = 1'b1; writeaddr = 5'd5; writedata = 32'hDEADBEEF;
    tick();
    regwrite = 1'b0; readaddr1 = 5'd5; readaddr2 = 5'd5;
    #1;
    chk("wr5_rd1", readdata1, 32'hDEADBEEF);
    chk("wr5_rd2", readdata2, 32'hDEADBEEF);

    // Same-cycle bypass before the edge, then array holds it.
    regwrite = 1'b1; writeaddr = 5'd7; writedata = 32'h12345678;
    readaddr1 = 5'd7; readaddr2 = 5'd5;
    #1;
    chk("byp_rd1", readdata1, 32'h12345678);
    chk("byp_rd2_other", readdata2, 32'hDEADBEEF);
    tick();
    regwrite = 1'b0;
    #1;
    chk("byp_held_rd1", readdata1, 32'h12345678);

    // r0 writes are neither forwarded nor stored.
    regwrite = 1'b1; writeaddr = 5'd0; writedata = 32'hFFFFFFFF; readaddr1 = 5'd0;
    #1;
    chk("r0_byp_rd1", readdata1, 32'h0);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r0_after_rd1", readdata1, 32'h0);

    // Disabled read ports return zero.
    regread2 = 1'b0; readaddr2 = 5'd5;
    regread1 = 1'b0; readaddr1 = 5'd7;
    #1;
    chk("rd2_disabled", readdata2, 32'h0);
    chk("rd1_disabled", readdata1, 32'h0);
    regread1 = 1'b1; regread2 = 1'b1;

    // Load display register and check a full aligned scan.
    regwrite = 1'b1; writeaddr = 5'd23; writedata = 32'h00001234;
    tick();
    regwrite = 1'b0;
    wait_an(4'b1000, "wait_scan1_d3");
    wait_an(4'b0001, "wait_scan1_d0");
    chk_scan("scan1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

    // Mid-scan update must not tear the current scan.
    wait_an(4'b0100, "wait_mid_d2");
    regwrite = 1'b1; writeaddr = 5'd23; writedata = 32'h0000ABCD;
    tick();
    regwrite = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        chk($sformatf("tear_an_%0d", c), 32'(an), 32'h4);
        chk($sformatf("tear_leds_%0d", c), 32'(leds), 32'h5B);
      end else begin
        chk($sformatf("tear_an_%0d", c), 32'(an), 32'h8);
        chk($sformatf("tear_leds_%0d", c), 32'(leds), 32'h06);
      end
      tick();
    end
    chk_scan("scanABCD", 7'h5E, 7'h39, 7'h7C, 7'h77);

    // Reset mid-period restarts the scan at digit 0 for a full period.
    wait_an(4'b0100, "wait_rst_d2");
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_an", 32'(an), 32'h0);
    chk("midrst_leds", 32'(leds), 32'h0);
    rst = 1'b0;
    regread1 = 1'b1; readaddr1 = 5'd23;
    #1;
    chk("midrst_mem_clr", readdata1, 32'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rstscan_an_%0d", c), 32'(an), 32'h1);
      chk($sformatf("rstscan_leds_%0d", c), 32'(leds), 32'h3F);
      tick();
    end
    chk("rstscan_an_next", 32'(an), 32'h2);
    chk("rstscan_leds_next", 32'(leds), 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
